// File: rtl/vault_pkg.sv
// ============================================================================
// Module : vault_pkg
// Brief  : Shared state encoding and timing defaults for the vault controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vault_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } vault_state_t;

    localparam int c_tick_div     = 1048576;
    localparam int c_auth_window  = 8;
    localparam int c_open_time    = 16;
    localparam int c_max_fails    = 3;
    localparam int c_lockout_time = 32;

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module : tick_gen
// Brief  : Free-running prescaler, one-cycle Tick when the count wraps.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int TICK_DIV = 1048576
) (
    input  logic Clk,
    input  logic Reset_n,
    output logic Tick
);

    localparam int c_cw = $clog2(TICK_DIV);
    localparam logic [c_cw-1:0] c_last = c_cw'(TICK_DIV - 1);

    logic [c_cw-1:0] r_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cw'(1);
        end
    end

    assign Tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/quorum_vault_controller.sv
// ============================================================================
// Module : quorum_vault_controller
// Brief  : Quorum-based vault unlock FSM with approval window, auto-relock
//          and lockout after repeated failed sessions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module quorum_vault_controller
    import vault_pkg::*;
#(
    parameter int NUM_VP        = 4,
    parameter int OPEN_QUORUM   = 1,
    parameter int CLOSED_QUORUM = 2,
    parameter int TICK_DIV      = c_tick_div,
    parameter int AUTH_WINDOW   = c_auth_window,
    parameter int OPEN_TIME     = c_open_time,
    parameter int MAX_FAILS     = c_max_fails,
    parameter int LOCKOUT_TIME  = c_lockout_time
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             BankTiming,
    input  logic                             Request,
    input  logic                             PresidentAuth,
    input  logic [NUM_VP-1:0]                VPAuth,
    input  logic                             GuardAvailable,
    output logic                             VaultStatus,
    output logic [1:0]                       State,
    output logic [$clog2(MAX_FAILS+1)-1:0]   FailCount,
    output logic                             Alarm
);

    localparam int c_fw     = $clog2(MAX_FAILS + 1);
    localparam int c_pw     = $clog2(NUM_VP + 1);
    localparam int c_tmax_a = (AUTH_WINDOW > OPEN_TIME) ? AUTH_WINDOW : OPEN_TIME;
    localparam int c_tmax   = (c_tmax_a > LOCKOUT_TIME) ? c_tmax_a : LOCKOUT_TIME;
    localparam int c_tw     = $clog2(c_tmax + 1);

    vault_state_t      r_state;
    logic [c_tw-1:0]   r_timer;
    logic [c_fw-1:0]   r_fails;
    logic              r_pres;
    logic [NUM_VP-1:0] r_vp;
    logic              r_vault;
    logic              r_alarm;
    logic              r_req_d;
    logic              r_armed;

    logic              w_tick;
    logic              w_req_edge;
    logic              w_pres_all;
    logic [NUM_VP-1:0] w_vp_all;
    logic [c_pw-1:0]   w_vp_cnt;
    logic [c_pw-1:0]   w_quorum;
    logic              w_grant;
    logic              w_expire;
    logic [c_fw-1:0]   w_fail_next;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Tick    (w_tick)
    );

    // r_armed blocks a Request that was already high when reset released.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_req_d <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_req_d <= Request;
            if (!Request) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_req_edge = Request & ~r_req_d & r_armed;

    assign w_pres_all = r_pres | PresidentAuth;
    assign w_vp_all   = r_vp | VPAuth;

    always_comb begin
        w_vp_cnt = '0;
        for (int i = 0; i < NUM_VP; i++) begin
            w_vp_cnt = w_vp_cnt + c_pw'(w_vp_all[i]);
        end
    end

    assign w_quorum    = BankTiming ? c_pw'(OPEN_QUORUM) : c_pw'(CLOSED_QUORUM);
    assign w_grant     = GuardAvailable & (w_pres_all | (w_vp_cnt >= w_quorum));
    // A timer "reaches 0" on the tick that would take it from 1 to 0.
    assign w_expire    = w_tick & (r_timer <= c_tw'(1));
    assign w_fail_next = (r_fails == c_fw'(MAX_FAILS)) ? r_fails : r_fails + c_fw'(1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_fails <= '0;
            r_pres  <= 1'b0;
            r_vp    <= '0;
            r_vault <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_edge) begin
                        r_state <= ST_COLLECT;
                        r_pres  <= 1'b0;
                        r_vp    <= '0;
                        r_timer <= c_tw'(AUTH_WINDOW);
                    end
                end
                ST_COLLECT: begin
                    r_pres <= w_pres_all;
                    r_vp   <= w_vp_all;
                    if (w_tick && r_timer != '0) begin
                        r_timer <= r_timer - c_tw'(1);
                    end
                    if (w_grant) begin
                        r_state <= ST_OPEN;
                        r_vault <= 1'b1;
                        r_fails <= '0;
                        r_timer <= c_tw'(OPEN_TIME);
                    end else if (w_expire) begin
                        r_fails <= w_fail_next;
                        if (w_fail_next == c_fw'(MAX_FAILS)) begin
                            r_state <= ST_LOCKOUT;
                            r_alarm <= 1'b1;
                            r_timer <= c_tw'(LOCKOUT_TIME);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_OPEN: begin
                    if (!GuardAvailable || w_expire) begin
                        r_state <= ST_IDLE;
                        r_vault <= 1'b0;
                    end else if (w_tick) begin
                        r_timer <= r_timer - c_tw'(1);
                    end
                end
                ST_LOCKOUT: begin
                    if (w_expire || (PresidentAuth && GuardAvailable)) begin
                        r_state <= ST_IDLE;
                        r_alarm <= 1'b0;
                        r_fails <= '0;
                    end else if (w_tick) begin
                        r_timer <= r_timer - c_tw'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_vault <= 1'b0;
                    r_alarm <= 1'b0;
                end
            endcase
        end
    end

    assign State       = r_state;
    assign VaultStatus = r_vault;
    assign FailCount   = r_fails;
    assign Alarm       = r_alarm;

endmodule

`default_nettype wire

// File: doc/quorum_vault_controller.md
QUORUM_VAULT_CONTROLLER -- requirements
Module: quorum_vault_controller

Interface
REQ-001 SHALL have parameter NUM_VP, 4, number of vice-president approver inputs (2..8).
REQ-002 SHALL have parameter OPEN_QUORUM, 1, VP approvals needed during open hours (1..CLOSED_QUORUM).
REQ-003 SHALL have parameter CLOSED_QUORUM, 2, VP approvals needed during closed hours (OPEN_QUORUM..NUM_VP).
REQ-004 SHALL have parameter TICK_DIV, 1048576, Clk cycles per timer tick (>=2).
REQ-005 SHALL have parameter AUTH_WINDOW, 8, ticks allowed for collecting approvals.
REQ-006 SHALL have parameter OPEN_TIME, 16, ticks vault stays open before auto-relock.
REQ-007 SHALL have parameter MAX_FAILS, 3, consecutive expired windows that trigger lockout.
REQ-008 SHALL have parameter LOCKOUT_TIME, 32, ticks of lockout.
REQ-009 Ports: one clock; reset is asynchronous and active-low.
REQ-010 Clk  input  1  sampling clock, all logic on rising edge.
REQ-011 Reset_n  input  1  asynchronous active-low reset.
REQ-012 BankTiming  input  1  1=open hours, 0=closed hours.
REQ-013 Request  input  1  level; rising edge starts an authentication session.
REQ-014 PresidentAuth  input  1  president approval.
REQ-015 VPAuth  input  NUM_VP  per-VP approval levels.
REQ-016 GuardAvailable  input  1  guard present.
REQ-017 VaultStatus  output  1  1=vault unlocked.
REQ-018 State  output  2  IDLE=0, COLLECT=1, OPEN=2, LOCKOUT=3.
REQ-019 FailCount  output  clog2(MAX_FAILS+1)  consecutive failed sessions.
REQ-020 Alarm  output  1  1 while in LOCKOUT.

Function
REQ-021 Prescaler SHALL count 0..TICK_DIV-1 and assert a one-cycle internal Tick on wrap; it SHALL run freely in all states.
REQ-022 Request rising edge SHALL be detected from a registered copy; a level held high SHALL not start a second session.
REQ-023 IDLE: on Request edge -> COLLECT next cycle; approval latch cleared, window timer loaded with AUTH_WINDOW.
REQ-024 COLLECT: approval latch SHALL OR in VPAuth and PresidentAuth every cycle (sticky); window timer decrements on Tick.
REQ-025 Grant = GuardAvailable AND (latched president OR popcount(latched VPs) >= quorum), quorum = OPEN_QUORUM if current BankTiming=1 else CLOSED_QUORUM; popcount width clog2(NUM_VP+1).
REQ-026 Grant in cycle N SHALL give State=OPEN and VaultStatus=1 in cycle N+1, FailCount cleared, open timer loaded with OPEN_TIME.
REQ-027 Window timer reaching 0 without grant: FailCount+1; if new value = MAX_FAILS -> LOCKOUT (timer loaded LOCKOUT_TIME) else IDLE.
REQ-028 Grant and window expiry in the same cycle: grant wins, no fail recorded.
REQ-029 OPEN: open timer decrements on Tick; at 0 -> IDLE, VaultStatus=0 next cycle.
REQ-030 OPEN: GuardAvailable=0 in cycle N -> IDLE, VaultStatus=0 in cycle N+1, regardless of timer.
REQ-031 Request edges SHALL be ignored in COLLECT, OPEN and LOCKOUT; BankTiming changes SHALL not affect OPEN.
REQ-032 LOCKOUT: Alarm=1, VaultStatus=0; exit to IDLE when lockout timer reaches 0 or on PresidentAuth AND GuardAvailable; either exit clears FailCount.
REQ-033 FailCount SHALL saturate at MAX_FAILS, never wrap.

Reset
REQ-034 Reset_n=0 SHALL immediately force State=IDLE, VaultStatus=0, Alarm=0, FailCount=0, clear prescaler, timers, approval latch and edge register, including mid-session or mid-OPEN.
REQ-035 After Reset_n rises, a Request already high SHALL not start a session until it falls and rises again.

Structure
REQ-036 State encoding and the TICK_DIV/AUTH_WINDOW/OPEN_TIME/MAX_FAILS/LOCKOUT_TIME defaults SHALL live in shared package vault_pkg.
REQ-037 Prescaler SHALL be a separate sub-module tick_gen (parameter TICK_DIV, ports Clk, Reset_n, Tick).

Verification (bench overrides TICK_DIV=4, other defaults)
REQ-038 BankTiming=1, Guard=1, Request edge, VPAuth=4'b0001 -> State=OPEN, VaultStatus=1 one cycle after grant; VaultStatus=0 after 16 ticks (64 cycles).
REQ-039 BankTiming=0, Guard=1, VPAuth=4'b0001 only -> no grant; after 8 ticks FailCount=1, State=IDLE; then VPAuth bits 0 and 2 pulsed at different cycles -> OPEN (sticky latch).
REQ-040 Three sessions with no approvals -> FailCount=3, State=LOCKOUT, Alarm=1; Request edges ignored; after 32 ticks State=IDLE, FailCount=0.
REQ-041 In LOCKOUT, PresidentAuth=1 and Guard=1 -> IDLE next cycle; in OPEN, Guard dropped -> VaultStatus=0 next cycle.
REQ-042 Grant on same cycle as window expiry -> OPEN, FailCount unchanged at 0; Reset_n pulsed low in OPEN -> VaultStatus=0 immediately, all outputs at reset values.
